fft_p2s: RTL and testbench
==========================

Name: fft_p2s

Overview:
Parallel-to-serial unpacker at the output of the FFT stage; the inverse of the serial-to-parallel gatherer ahead of the FFT.
- Captures one 16-bin FFT frame (16 x 32-bit words) in a single cycle when fft_valid pulses.
- Streams the words out one per handshake on a valid/ready interface with bin index and last-word marker, for host readout or a downstream serial consumer.

Parameters:
N, 16, bins per frame (fixed at 16; index width 4)
W, 32, bin word width ({real[31:16], imag[15:0]}, passed through unmodified)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  one-cycle frame strobe (driven by fft_valid)
in_d0 .. in_d15  input  32 each  FFT bin words 0..15
in_ready  output  1  block can accept a frame this cycle
out_valid  output  1  out_data holds a valid bin word
out_ready  input  1  downstream accepts the word this cycle
out_data  output  32  current bin word
out_idx  output  4  bin index of out_data
out_last  output  1  high with the final word of a frame
overrun  output  1  sticky: a frame arrived while in_ready was low and was dropped

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, overrun=0, frame buffer cleared to 0. in_ready evaluates to 1.
- States:
  - IDLE: no frame held.
  - STREAM: frame buffer held, count = next word position (0..15).
- in_ready is combinational: (state==IDLE) OR (out_valid AND out_ready AND out_last).
  - This allows back-to-back frames with no bubble.
- Capture: in_valid AND in_ready at an edge latches all 16 inputs into the buffer, sets count=0 and enters STREAM.
- Latency: out_valid rises, carrying word 0, on the cycle after the capture edge (1 cycle).
- Each out_valid AND out_ready edge advances count. out_data, out_idx and out_last update from the buffer at the same edge.
  - While out_ready=0: out_data, out_idx and out_last hold stable, and out_valid stays 1.
- out_last = 1 exactly when count==15.
- End of frame (last word accepted):
  - Simultaneous in_valid: the new frame is captured and word 0 of the new frame follows on the next cycle. out_valid stays 1 continuously.
  - Otherwise: return to IDLE, out_valid=0, out_last=0. out_data and out_idx hold their last values.
- Overrun: in_valid AND NOT in_ready sets overrun=1. The incoming frame is discarded and the frame in flight is not disturbed. overrun is cleared only by rst.
- out_valid never drops mid-frame. Exactly 16 handshakes per accepted frame.
- Reset mid-stream: the current frame is abandoned immediately. All outputs return to reset values on the next edge.
- No arithmetic; words pass through bit-exact.

Optional Feature:
- Macro: FFT_P2S_BITREV_EN.
- Defined: words are emitted in bit-reversed bin order (position p emits bin bitrev4(p): 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15). out_idx reports the true bin number of the word; out_last is still tied to position 15.
- Undefined: natural order 0..15; out_idx equals the position.

Decomposition:
- Shared package fas_pkg:
  - constants FFT_N=16, FFT_W=32, IDX_W=4
  - state enum {IDLE, STREAM}
  - function bitrev4
- The FIR, S2P and FFT stages use the same package constants.
- One natural sub-module, p2s_word_mux: a 16:1 selector of buffer words by position, optionally remapped through bitrev4.
- Counter, state machine and handshake stay in fft_p2s.

Test Plan:
- Reset, then in_valid with in_d_k = 32'h0001_0000*k + k, out_ready held 1:
  - out_valid high on cycles 1..16 after capture
  - out_data = 32'h0000_0000, 32'h0001_0001, … 32'h000F_000F
  - out_idx = 0..15; out_last only on the 16th word
  - then IDLE with in_ready=1
- Same frame with out_ready toggled 1,0,0,1,…:
  - each word held stable while out_ready=0
  - 16 handshakes in total, no word skipped or duplicated
- Frame A captured, then frame B presented on the cycle the last word of A is accepted:
  - A words 0..15 followed immediately by B words 0..15
  - out_valid never deasserts; overrun stays 0
- in_valid asserted while streaming word 5 of frame A:
  - overrun=1 on the next cycle and remains 1
  - A completes intact; B is never output
- rst asserted during word 7:
  - next edge gives out_valid=0, out_idx=0, overrun=0, in_ready=1
  - a fresh frame afterwards streams from word 0
- FFT_P2S_BITREV_EN defined, same stimulus as the first scenario:
  - out_idx sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15
  - out_data matches the bin given by out_idx; out_last on the 16th word

Source files
------------

// File: rtl/fas_pkg.sv
// Shared constants, types and helpers for the FIR / S2P / FFT / P2S chain.
package fas_pkg;

  localparam int FFT_N = 16;  // bins per frame
  localparam int FFT_W = 32;  // bin word width: {real[31:16], imag[15:0]}
  localparam int IDX_W = 4;   // bin index width

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } p2s_state_e;

  // Reverse the four bits of a bin position (radix-2 FFT output ordering).
  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] p);
    return {p[0], p[1], p[2], p[3]};
  endfunction

endpackage

// File: rtl/p2s_word_mux.sv
// 16:1 selector of frame buffer words by output position.
// With FFT_P2S_BITREV_EN defined, the position is remapped through bitrev4
// so words leave in bit-reversed bin order; idx always reports the true bin.
module p2s_word_mux
  import fas_pkg::*;
(
  input  logic [FFT_N-1:0][FFT_W-1:0] words,
  input  logic [IDX_W-1:0]            pos,
  output logic [FFT_W-1:0]            word,
  output logic [IDX_W-1:0]            idx
);

  // Map position to bin, then pick that bin's word.
  always_comb begin
`ifdef FFT_P2S_BITREV_EN
    idx = bitrev4(pos);
`else
    idx = pos;
`endif
    word = words[idx];
  end

endmodule

// File: rtl/fft_p2s.sv
// FFT output parallel-to-serial unpacker: captures a 16-word frame in one
// cycle and streams it out one word per valid/ready handshake.
// Optional macro: FFT_P2S_BITREV_EN (bit-reversed emission order).
//
// Handshake: a word transfers on any rising edge where out_valid and
// out_ready are both high; out_valid never drops while a frame is in flight
// and out_data/out_idx/out_last hold stable until the word is taken.
// in_ready is combinational so the next frame can be captured on the same
// edge that the last word of the current frame is accepted.
module fft_p2s
  import fas_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [FFT_W-1:0] in_d0,
  input  logic [FFT_W-1:0] in_d1,
  input  logic [FFT_W-1:0] in_d2,
  input  logic [FFT_W-1:0] in_d3,
  input  logic [FFT_W-1:0] in_d4,
  input  logic [FFT_W-1:0] in_d5,
  input  logic [FFT_W-1:0] in_d6,
  input  logic [FFT_W-1:0] in_d7,
  input  logic [FFT_W-1:0] in_d8,
  input  logic [FFT_W-1:0] in_d9,
  input  logic [FFT_W-1:0] in_d10,
  input  logic [FFT_W-1:0] in_d11,
  input  logic [FFT_W-1:0] in_d12,
  input  logic [FFT_W-1:0] in_d13,
  input  logic [FFT_W-1:0] in_d14,
  input  logic [FFT_W-1:0] in_d15,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FFT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             overrun
);

  p2s_state_e                  state_q, state_d;
  logic [FFT_N-1:0][FFT_W-1:0] buf_q, buf_d, in_words;
  logic [IDX_W-1:0]            pos_q, pos_d, pos_nxt;
  logic [FFT_W-1:0]            data_q, data_d, mux_word;
  logic [IDX_W-1:0]            idx_q, idx_d, mux_idx;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        overrun_q, overrun_d;
  logic                        accept, capture;

  assign in_words = {in_d15, in_d14, in_d13, in_d12, in_d11, in_d10, in_d9, in_d8,
                     in_d7,  in_d6,  in_d5,  in_d4,  in_d3,  in_d2,  in_d1, in_d0};

  // The mux looks one position ahead so the next word is ready at accept.
  assign pos_nxt = pos_q + IDX_W'(1);

  p2s_word_mux u_mux (
    .words (buf_q),
    .pos   (pos_nxt),
    .word  (mux_word),
    .idx   (mux_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: capture wins over end-of-frame so back-to-back frames chain.
  always_comb begin
    state_d = state_q;
    if (capture)               state_d = STREAM;
    else if (accept && last_q) state_d = IDLE;
  end

  // Handshake outputs and strobes derived from the current state.
  always_comb begin
    accept   = valid_q && out_ready;
    in_ready = (state_q == IDLE) || (accept && last_q);
    capture  = in_valid && in_ready;
  end

  // Datapath next values: frame buffer, position, output word and flags.
  always_comb begin
    buf_d     = buf_q;
    pos_d     = pos_q;
    data_d    = data_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    overrun_d = overrun_q | (in_valid & ~in_ready);
    if (capture) begin
      // Position 0 is bin 0 in both orders, so word 0 comes straight from
      // the inputs while the buffer loads on the same edge.
      buf_d   = in_words;
      pos_d   = '0;
      data_d  = in_d0;
      idx_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (accept) begin
      if (last_q) begin
        // Frame done: data and index keep their last values.
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        pos_d  = pos_nxt;
        data_d = mux_word;
        idx_d  = mux_idx;
        last_d = (pos_nxt == IDX_W'(FFT_N - 1));
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '0;
      pos_q     <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      pos_q     <= pos_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_p2s.sv
// Directed, table-driven bench for fft_p2s.
module tb_fft_p2s;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] in_d [16];
  logic        in_ready, out_valid, out_last, overrun;
  logic [31:0] out_data;
  logic [3:0]  out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  fft_p2s dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_d0(in_d[0]),   .in_d1(in_d[1]),   .in_d2(in_d[2]),   .in_d3(in_d[3]),
    .in_d4(in_d[4]),   .in_d5(in_d[5]),   .in_d6(in_d[6]),   .in_d7(in_d[7]),
    .in_d8(in_d[8]),   .in_d9(in_d[9]),   .in_d10(in_d[10]), .in_d11(in_d[11]),
    .in_d12(in_d[12]), .in_d13(in_d[13]), .in_d14(in_d[14]), .in_d15(in_d[15]),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .overrun(overrun)
  );

  // Vector tables
  typedef struct {
    logic       out_ready;
    logic       exp_valid;
    logic [3:0] exp_bin;
    logic       exp_last;
  } vec_t;

  vec_t       tbl_full [16];
  vec_t       tbl_tog  [48];
  int         n_tog;
  logic [3:0] order    [16];

  // Scoreboard helpers
  function automatic logic [31:0] exp_word(input int frame, input logic [3:0] bin);
    if (frame == 0) return 32'h0001_0000 * 32'(bin) + 32'(bin);
    else            return 32'hB0B0_0000 + 32'h0011_0001 * 32'(bin);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int frame);
    for (int k = 0; k < 16; k++) in_d[k] = exp_word(frame, 4'(k));
  endtask

  task automatic capture(input int frame);
    load_frame(frame);
    in_valid = 1'b1;
    #1;
    check("capture_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_rows(input int which, input int first, input int last, input int frame);
    vec_t r;
    for (int i = first; i <= last; i++) begin
      r = (which == 0) ? tbl_full[i] : tbl_tog[i];
      out_ready = r.out_ready;
      #1;
      check("row_valid", 32'(out_valid), 32'(r.exp_valid));
      check("row_data",  out_data, exp_word(frame, r.exp_bin));
      check("row_idx",   32'(out_idx), 32'(r.exp_bin));
      check("row_last",  32'(out_last), 32'(r.exp_last));
      step();
    end
  endtask

  initial begin
    int pos;
    logic rdy;

    // Emission order, written out by hand.
`ifdef FFT_P2S_BITREV_EN
    order = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
              4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
`else
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
              4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif
    for (int p = 0; p < 16; p++)
      tbl_full[p] = '{1'b1, 1'b1, order[p], (p == 15)};
    // out_ready pattern 1,0,0,1,0,0,...; position advances only on a 1.
    pos = 0;
    n_tog = 0;
    while (pos < 16) begin
      rdy = (n_tog % 3 == 0);
      tbl_tog[n_tog] = '{rdy, 1'b1, order[pos], (pos == 15)};
      if (rdy) pos++;
      n_tog++;
    end

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) in_d[k] = '0;
    repeat (3) step();
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_data",     out_data, 32'd0);
    check("rst_idx",      32'(out_idx), 32'd0);
    check("rst_last",     32'(out_last), 32'd0);
    check("rst_overrun",  32'(overrun), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // 1: single frame, out_ready held high
    out_ready = 1'b1;
    capture(0);
    run_rows(0, 0, 15, 0);
    #1;
    check("s1_idle_valid",    32'(out_valid), 32'd0);
    check("s1_idle_last",     32'(out_last), 32'd0);
    check("s1_idle_in_ready", 32'(in_ready), 32'd1);
    check("s1_hold_idx",      32'(out_idx), 32'(order[15]));
    check("s1_hold_data",     out_data, exp_word(0, order[15]));

    // 2: same frame, out_ready toggled 1,0,0,1,...
    capture(0);
    run_rows(1, 0, n_tog - 1, 0);
    #1;
    check("s2_done_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // 3: frame B presented as the last word of A is accepted
    capture(0);
    run_rows(0, 0, 14, 0);
    out_ready = 1'b1;
    load_frame(1);
    in_valid = 1'b1;
    #1;
    check("s3_a_last",   32'(out_last), 32'd1);
    check("s3_a_data",   out_data, exp_word(0, order[15]));
    check("s3_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    run_rows(0, 0, 15, 1);
    #1;
    check("s3_end_valid",   32'(out_valid), 32'd0);
    check("s3_end_overrun", 32'(overrun), 32'd0);

    // 4: frame B arrives while word 5 of A is on the output
    capture(0);
    run_rows(0, 0, 4, 0);
    out_ready = 1'b1;
    load_frame(1);
    in_valid = 1'b1;
    #1;
    check("s4_in_ready", 32'(in_ready), 32'd0);
    check("s4_idx5",     32'(out_idx), 32'(order[5]));
    step();
    in_valid = 1'b0;
    check("s4_overrun_set", 32'(overrun), 32'd1);
    run_rows(0, 6, 15, 0);
    #1;
    check("s4_overrun_sticky", 32'(overrun), 32'd1);
    check("s4_end_valid",      32'(out_valid), 32'd0);

    // 5: reset while word 7 is on the output
    capture(0);
    run_rows(0, 0, 6, 0);
    #1;
    check("s5_idx7", 32'(out_idx), 32'(order[7]));
    rst = 1'b1;
    step();
    check("s5_rst_valid",    32'(out_valid), 32'd0);
    check("s5_rst_idx",      32'(out_idx), 32'd0);
    check("s5_rst_data",     out_data, 32'd0);
    check("s5_rst_last",     32'(out_last), 32'd0);
    check("s5_rst_overrun",  32'(overrun), 32'd0);
    check("s5_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    capture(1);
    run_rows(0, 0, 15, 1);
    #1;
    check("s5_end_valid", 32'(out_valid), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
